// File: rtl/lib_switchblock_pkg.sv
// Shared types and constants for the DEM switching tree and its swap scheduler.
package lib_switchblock_pkg;

  localparam int unsigned INPUT_WIDTH = 8;
  localparam int unsigned NUM_NODES   = 7;
  localparam int unsigned LFSR_W      = 16;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;
  // Feedback taps l[15], l[13], l[12], l[10]
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_RANDOM = 2'b01,
    MODE_SHAPE  = 2'b10,
    MODE_ROTATE = 2'b11
  } dem_mode_t;

  // One step of the left-shifting Fibonacci LFSR
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dem_node_split.sv
// One DEM tree node: splits value v into two children; swap s picks who gets the odd LSB.
module dem_node_split
  import lib_switchblock_pkg::*;
(
  input  logic [INPUT_WIDTH-1:0] v_i,
  input  logic                   s_i,
  output logic [INPUT_WIDTH-1:0] left_o,
  output logic [INPUT_WIDTH-1:0] right_o,
  output logic                   odd_o
);

  logic [INPUT_WIDTH-1:0] half;

  // Split rule: left gets the extra LSB when s=0, right when s=1
  always_comb begin
    half    = v_i >> 1;
    odd_o   = v_i[0];
    left_o  = half + {{(INPUT_WIDTH-1){1'b0}}, v_i[0] & ~s_i};
    right_o = half + {{(INPUT_WIDTH-1){1'b0}}, v_i[0] & s_i};
  end

endmodule

// File: rtl/dem_swap_scheduler.sv
// Per-sample swap-word generator for the 7-node DEM tree (PASS/RANDOM/SHAPE/ROTATE).
// Optional feature macro: DEM_SCHED_RANDOM_EN (LFSR, seed ports, RANDOM mode).
module dem_swap_scheduler
  import lib_switchblock_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [INPUT_WIDTH-1:0] x_in_i,
  input  logic                   sample_valid_i,
  input  logic [1:0]             mode_i,
  input  logic                   mode_load_i,
  input  logic [LFSR_W-1:0]      seed_i,
  input  logic                   seed_load_i,
  output logic [INPUT_WIDTH-1:0] x_aligned_o,
  output logic [NUM_NODES-1:0]   swap_o,
  output logic                   swap_valid_o,
  output logic [1:0]             mode_o
);

  dem_mode_t              pend_q, active_q, eff_mode;
  logic [NUM_NODES-1:0]   t_q, t_eff, t_d;
  logic                   r_q, r_eff, r_d;
  logic [NUM_NODES-1:0]   swap_d, odd_v;
  logic [INPUT_WIDTH-1:0] x_q;
  logic [NUM_NODES-1:0]   swap_q;
  logic                   valid_q;
  logic                   mode_chg;

  logic [INPUT_WIDTH-1:0] node_v  [NUM_NODES];
  logic [INPUT_WIDTH-1:0] left_v  [NUM_NODES];
  logic [INPUT_WIDTH-1:0] right_v [NUM_NODES];

`ifdef DEM_SCHED_RANDOM_EN
  logic [LFSR_W-1:0] lfsr_q;

  // LFSR: seed load has priority; otherwise advance once per accepted sample
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= SEED_DEFAULT;
    end else if (seed_load_i) begin
      lfsr_q <= (seed_i == '0) ? SEED_DEFAULT : seed_i;
    end else if (sample_valid_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^{seed_i, seed_load_i};
`endif

  // Mode resolution, swap-word selection and next shaping/rotate state
  always_comb begin
    // A same-cycle mode_load_i bypasses the pending register so it applies to this sample
    eff_mode = mode_load_i ? dem_mode_t'(mode_i) : pend_q;
    mode_chg = (eff_mode != active_q);
    t_eff    = mode_chg ? '0 : t_q;
    r_eff    = mode_chg ? 1'b0 : r_q;
    swap_d   = '0;
    case (eff_mode)
`ifdef DEM_SCHED_RANDOM_EN
      MODE_RANDOM: swap_d = lfsr_q[NUM_NODES-1:0];
`endif
      MODE_SHAPE:  swap_d = t_eff;
      MODE_ROTATE: swap_d = {NUM_NODES{r_eff}};
      default:     swap_d = '0;
    endcase
    t_d = (eff_mode == MODE_SHAPE)  ? (t_eff ^ odd_v) : t_eff;
    r_d = (eff_mode == MODE_ROTATE) ? ~r_eff : r_eff;
  end

  // Tree of node splitters: node k has children 2k+1 (left) and 2k+2 (right)
  for (genvar lyr = 0; lyr < 3; lyr++) begin : g_layer
    for (genvar n = 0; n < (1 << lyr); n++) begin : g_node
      localparam int unsigned K = (1 << lyr) - 1 + n;
      if (lyr == 0) begin : g_root
        assign node_v[K] = x_in_i;
      end else if ((n % 2) == 0) begin : g_left
        assign node_v[K] = left_v[(1 << (lyr - 1)) - 1 + n / 2];
      end else begin : g_right
        assign node_v[K] = right_v[(1 << (lyr - 1)) - 1 + n / 2];
      end
      dem_node_split u_split (
        .v_i     (node_v[K]),
        .s_i     (swap_d[K]),
        .left_o  (left_v[K]),
        .right_o (right_v[K]),
        .odd_o   (odd_v[K])
      );
    end
  end

  // Mode/state registers and the re-timed code/swap outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q   <= MODE_PASS;
      active_q <= MODE_PASS;
      t_q      <= '0;
      r_q      <= 1'b0;
      x_q      <= '0;
      swap_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (mode_load_i) begin
        pend_q <= dem_mode_t'(mode_i);
      end
      valid_q <= sample_valid_i;
      if (sample_valid_i) begin
        active_q <= eff_mode;
        t_q      <= t_d;
        r_q      <= r_d;
        x_q      <= x_in_i;
        swap_q   <= swap_d;
      end
    end
  end

  assign x_aligned_o  = x_q;
  assign swap_o       = swap_q;
  assign swap_valid_o = valid_q;
  assign mode_o       = active_q;

endmodule
